// File: rtl/dpos_quant_stream_pkg.sv
// Shared types for the graph-conv front end: pixel index widths, quantised
// output type, dx/dy computation mode and the streaming FSM states.
package dpos_quant_stream_pkg;

    localparam int unsigned X_PIXEL_WIDTH = 10;
    localparam int unsigned Y_PIXEL_WIDTH = 9;
    localparam int unsigned EXT_BITS      = 1;
    localparam int unsigned P_WIDTH       = 16;

    // One width for both axes so dx and dy share the difference/scale path.
    localparam int unsigned D_W =
        ((X_PIXEL_WIDTH > Y_PIXEL_WIDTH) ? X_PIXEL_WIDTH : Y_PIXEL_WIDTH) + EXT_BITS;

    typedef logic [X_PIXEL_WIDTH-1:0] x_idx_t;
    typedef logic [Y_PIXEL_WIDTH-1:0] y_idx_t;
    typedef logic [P_WIDTH-1:0]       p_t;
    typedef logic [D_W-1:0]           d_t;

    typedef enum logic { ABS = 1'b0, SIGNED = 1'b1 } dpos_mode_e;

    typedef enum logic [1:0] { IDLE, STREAM, DRAIN } dpos_state_e;

    function automatic d_t abs_diff(input d_t a, input d_t b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/dpos_quant_stream_sat_mul.sv
// Combinational multiply-by-constant with saturation to p_t; unsigned
// operands clamp to the full range, signed ones to the two's-complement range.
module dpos_sat_mul
    import dpos_quant_stream_pkg::*;
#(
    parameter dpos_mode_e  MODE  = ABS,
    parameter int unsigned SCALE = 256,
    parameter int unsigned IN_W  = D_W
) (
    input  logic [IN_W-1:0] d,
    output p_t              q
);

    localparam int unsigned PROD_W = IN_W + 33;

    localparam logic signed [PROD_W-1:0] SCALE_EXT = PROD_W'(SCALE);
    localparam logic signed [PROD_W-1:0] U_MAX     = (PROD_W'(1) << P_WIDTH) - PROD_W'(1);
    localparam logic signed [PROD_W-1:0] S_MAX     = (PROD_W'(1) << (P_WIDTH - 1)) - PROD_W'(1);
    localparam logic signed [PROD_W-1:0] S_MIN     = -(PROD_W'(1) << (P_WIDTH - 1));

    logic signed [PROD_W-1:0] d_ext;
    logic signed [PROD_W-1:0] prod;

    always_comb begin
        if (MODE == SIGNED) begin
            d_ext = PROD_W'($signed(d));
        end else begin
            d_ext = PROD_W'(d);
        end
        prod = d_ext * SCALE_EXT;
        q    = prod[P_WIDTH-1:0];
        if (MODE == SIGNED) begin
            if (prod > S_MAX) begin
                q = S_MAX[P_WIDTH-1:0];
            end else if (prod < S_MIN) begin
                q = S_MIN[P_WIDTH-1:0];
            end
        end else if (prod > U_MAX) begin
            q = U_MAX[P_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/dpos_quant_stream.sv
// Latches one event, then streams its neighbours through a two-stage
// relative-position quantiser with valid/ready back-pressure.
module dpos_quant_stream
    import dpos_quant_stream_pkg::*;
#(
    parameter int unsigned Q_SCALE     = 255,
    parameter int unsigned Q_DPOS      = 256,
    parameter int unsigned SIGNED_MODE = 0,
    parameter int unsigned RADIUS      = 255,
    parameter int unsigned MAX_NBR     = 16,
    parameter int unsigned CNT_W       = $clog2(MAX_NBR + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ev_valid,
    output logic             ev_ready,
    input  x_idx_t           ev_x,
    input  y_idx_t           ev_y,
    input  logic             ev_p,
    input  logic             nb_valid,
    output logic             nb_ready,
    input  x_idx_t           nb_x,
    input  y_idx_t           nb_y,
    input  logic             nb_p,
    input  logic             nb_last,
    output logic             out_valid,
    input  logic             out_ready,
    output p_t               q_dx,
    output p_t               q_dy,
    output p_t               q_new_p,
    output p_t               q_neighbor_p,
    output logic             done,
    output logic [CNT_W-1:0] nbr_cnt,
    output logic             ovf
);

    localparam dpos_mode_e MODE  = (SIGNED_MODE != 0) ? SIGNED : ABS;
    localparam p_t         Q_POL = P_WIDTH'(Q_SCALE);

    dpos_state_e      state, state_nx;
    x_idx_t           ev_x_r;
    y_idx_t           ev_y_r;
    logic             ev_p_r;
    logic [CNT_W-1:0] cnt;
    logic             ovf_acc;

    logic s1_valid, s1_keep, s1_p;
    d_t   s1_dx, s1_dy;
    logic s2_valid;
    p_t   dx_q, dy_q;

    d_t   ax, ay, sx, sy;
    logic in_radius, cnt_room;
    logic nb_fire, s1_go, s1_free, s2_free, drain_empty;

    always_comb begin
        ax        = abs_diff(D_W'(ev_x_r), D_W'(nb_x));
        ay        = abs_diff(D_W'(ev_y_r), D_W'(nb_y));
        sx        = D_W'(ev_x_r) - D_W'(nb_x);
        sy        = D_W'(ev_y_r) - D_W'(nb_y);
        in_radius = (32'(ax) <= RADIUS) && (32'(ay) <= RADIUS);
        cnt_room  = 32'(cnt) < MAX_NBR;
    end

    // Dropped slots leave stage 1 without needing stage 2 to be free.
    assign s2_free     = !s2_valid || out_ready;
    assign s1_go       = s1_valid && (!s1_keep || s2_free);
    assign s1_free     = !s1_valid || s1_go;
    assign nb_fire     = nb_valid && nb_ready;
    assign drain_empty = (state == DRAIN) && s1_free && !(s1_go && s1_keep) && s2_free;
    assign out_valid   = s2_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (ev_valid) state_nx = STREAM;
            STREAM:  if (nb_fire && nb_last) state_nx = DRAIN;
            DRAIN:   if (drain_empty) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        ev_ready = (state == IDLE);
        nb_ready = (state == STREAM) && s1_free;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ev_x_r  <= '0;
            ev_y_r  <= '0;
            ev_p_r  <= 1'b0;
            cnt     <= '0;
            ovf_acc <= 1'b0;
            done    <= 1'b0;
            nbr_cnt <= '0;
            ovf     <= 1'b0;
        end else begin
            done <= drain_empty;
            if (state == IDLE && ev_valid) begin
                ev_x_r  <= ev_x;
                ev_y_r  <= ev_y;
                ev_p_r  <= ev_p;
                cnt     <= '0;
                ovf_acc <= 1'b0;
            end else if (nb_fire && in_radius) begin
                if (cnt_room) begin
                    cnt <= cnt + CNT_W'(1);
                end else begin
                    ovf_acc <= 1'b1;
                end
            end
            if (drain_empty) begin
                nbr_cnt <= cnt;
                ovf     <= ovf_acc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_keep  <= 1'b0;
            s1_p     <= 1'b0;
            s1_dx    <= '0;
            s1_dy    <= '0;
        end else if (nb_fire) begin
            s1_valid <= 1'b1;
            s1_keep  <= in_radius && cnt_room;
            s1_p     <= nb_p;
            s1_dx    <= (MODE == SIGNED) ? sx : ax;
            s1_dy    <= (MODE == SIGNED) ? sy : ay;
        end else if (s1_go) begin
            s1_valid <= 1'b0;
        end
    end

    dpos_sat_mul #(.MODE(MODE), .SCALE(Q_DPOS), .IN_W(D_W)) u_sat_dx (.d(s1_dx), .q(dx_q));
    dpos_sat_mul #(.MODE(MODE), .SCALE(Q_DPOS), .IN_W(D_W)) u_sat_dy (.d(s1_dy), .q(dy_q));

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid     <= 1'b0;
            q_dx         <= '0;
            q_dy         <= '0;
            q_new_p      <= '0;
            q_neighbor_p <= '0;
        end else if (s1_go && s1_keep) begin
            s2_valid     <= 1'b1;
            q_dx         <= dx_q;
            q_dy         <= dy_q;
            q_new_p      <= ev_p_r ? Q_POL : '0;
            q_neighbor_p <= s1_p ? Q_POL : '0;
        end else if (out_ready) begin
            s2_valid <= 1'b0;
        end
    end

endmodule

// File: doc/dpos_quant_stream.md
Name: dpos_quant_stream

Overview:
- Successor to the single-pair relative-position quantiser in the graph-conv front end.
- Latches one new event, then streams up to MAX_NBR neighbours against it.
- Per neighbour it computes a radius-filtered, signed or absolute dx/dy, quantises it with saturation, and scales the polarities.
- Sits between the neighbour-search unit and the graph-conv MAC array. Full valid/ready back-pressure, 1 neighbour/cycle throughput.

Parameters:
- Q_SCALE, 255: polarity scale; q_p = p * Q_SCALE.
- Q_DPOS, 256: position scale; q_d = d * Q_DPOS.
- SIGNED_MODE, 0: 0 gives d = |new - nbr|; 1 gives signed two's-complement d = new - nbr.
- RADIUS, 255: neighbours with |dx| > RADIUS or |dy| > RADIUS are dropped.
- MAX_NBR, 16: maximum neighbours forwarded per event; excess are consumed and dropped.
- CNT_W, $clog2(MAX_NBR+1): width of the counter output.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- ev_valid  in  1  new-event valid.
- ev_ready  out  1  high only in IDLE.
- ev_x  in  x_idx_t  new-event x.
- ev_y  in  y_idx_t  new-event y.
- ev_p  in  1  new-event polarity.
- nb_valid  in  1  neighbour valid.
- nb_ready  out  1  neighbour accept.
- nb_x  in  x_idx_t  neighbour x.
- nb_y  in  y_idx_t  neighbour y.
- nb_p  in  1  neighbour polarity.
- nb_last  in  1  last neighbour of this event.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accept.
- q_dx  out  p_t  quantised dx.
- q_dy  out  p_t  quantised dy.
- q_new_p  out  p_t  quantised new-event polarity.
- q_neighbor_p  out  p_t  quantised neighbour polarity.
- done  out  1  one-cycle pulse at the end of the event.
- nbr_cnt  out  CNT_W  number of neighbours forwarded; valid with done.
- ovf  out  1  MAX_NBR was exceeded; valid with done.

Behaviour:
- Reset (rst high at a clk edge):
  - FSM goes to IDLE, both pipeline stages are emptied, counters clear.
  - All outputs are 0, except ev_ready, which is 1 (IDLE).
  - Reset mid-stream discards all in-flight results; no done pulse is issued.
- FSM states: IDLE, STREAM, DRAIN.
  - IDLE: ev_ready=1, nb_ready=0. On ev_valid, latch x/y/p, clear the count, go to STREAM.
  - STREAM: nb_ready = stage-1 free, or stage 1 advancing this cycle. A handshake with nb_last=1 goes to DRAIN.
  - DRAIN: nb_ready=0. When both stages are empty and the final out handshake is done, pulse done with nbr_cnt/ovf, then go to IDLE.
  - done is issued in the cycle after the last output is accepted. If no neighbours were kept, done is issued 2 cycles after the nb_last handshake.
- Pipeline stage 1 (register):
  - Compute dx/dy with one extra bit, abs or signed per SIGNED_MODE.
  - Evaluate the radius test on the magnitude.
  - Mark the slot "keep" when the test passes and the count before this neighbour is < MAX_NBR.
  - Otherwise the slot is consumed and set ovf (count overflow) or silently drop (radius).
  - The count increments on keep only.
- Pipeline stage 2 (output register):
  - Multiply by Q_DPOS and saturate to p_t.
    - Unsigned mode: clamp to 2^P_WIDTH-1.
    - Signed mode: clamp to [-2^(P_WIDTH-1), 2^(P_WIDTH-1)-1].
  - Polarities: q = p ? Q_SCALE : 0, zero-extended.
  - Only "keep" slots reach out_valid.
- Handshake and stalls:
  - Outputs are held stable while out_valid && !out_ready.
  - Stages advance when the downstream stage is free or draining.
  - Unstalled latency is 2 cycles from the nb handshake to out_valid.
- Boundaries:
  - nb_valid arriving in IDLE or DRAIN is not accepted.
  - nb_last on a dropped neighbour still ends the event.
  - Count equal to MAX_NBR is not overflow; MAX_NBR+1 neighbours give ovf=1 and nbr_cnt=MAX_NBR.
  - ev_valid during STREAM/DRAIN is ignored; ev_ready=0 there.

Decomposition:
- Shared aegnn package:
  - Existing: x_idx_t, y_idx_t, p_t, X_PIXEL_WIDTH, Y_PIXEL_WIDTH, EXT_BITS.
  - New: the dpos_mode_e enum (ABS, SIGNED) and the P_WIDTH constant.
- One sub-module, dpos_sat_mul: combinational multiply-by-constant with signed/unsigned saturation, instantiated for dx and dy in stage 2.
- The existing absolute-difference helper is reused in stage 1 for abs mode.

Test Plan:
- Abs mode, P_WIDTH=16: event (10,20,p=1); neighbour (13,18,p=0,last) -> q_dx=768, q_dy=512, q_new_p=255, q_neighbor_p=0; out_valid 2 cycles after the handshake; done with nbr_cnt=1.
- SIGNED_MODE=1, same stimulus -> q_dx=-768 (0xFD00), q_dy=512.
- Saturation: Q_DPOS=1024, dx=100 -> q_dx=65535 (unsigned). Signed mode, dx=-100 -> q_dx=-32768.
- RADIUS=5: neighbours dx=6 (dropped), dx=5 (kept), dx=2 (last) -> 2 outputs, nbr_cnt=2, ovf=0.
- MAX_NBR=4: stream 6 neighbours with out_ready toggling 1010… -> exactly 4 outputs in order, held stable while stalled, ovf=1, nbr_cnt=4.
- Assert rst while 2 results are in flight -> next cycle out_valid=0, done=0, ev_ready=1; a following event runs normally.
